// File: rtl/encoder_83_seq.sv
// Sequential 8:3 priority encoder: captures a multi-hot vector and emits one code per set bit.
// Optional one-hot checking on capture is enabled by defining ENCODER_83_SEQ_ONEHOT_CHECK_EN.
module encoder_83_seq #(
  parameter int LSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [7:0] req,
  output logic       req_ready,
  output logic [2:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       zero_err,
  output logic       multi_err
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic       zero_err_q, zero_err_d;
  logic [2:0] code_sel;
  logic [7:0] served_mask;

  // The later loop iteration wins, so the scan order sets the priority direction.
  always_comb begin
    code_sel = 3'd0;
    if (LSB_FIRST != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) code_sel = i[2:0];
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pending_q[i]) code_sel = i[2:0];
      end
    end
  end

  assign served_mask = 8'd1 << code_sel;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req != 8'h00) begin
            pending_d = req;
            state_d   = BUSY;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (code_ready) begin
          pending_d = pending_q & ~served_mask;
          if (pending_d == 8'h00) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= 8'h00;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end

`ifdef ENCODER_83_SEQ_ONEHOT_CHECK_EN
  logic multi_err_q, multi_err_d;

  // Clearing the lowest set bit leaves something behind only when more than one bit is set.
  always_comb begin
    multi_err_d = (state_q == IDLE) && req_valid && ((req & (req - 8'd1)) != 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) multi_err_q <= 1'b0;
    else        multi_err_q <= multi_err_d;
  end

  assign multi_err = multi_err_q;
`else
  assign multi_err = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE);
  assign code_valid = (state_q == BUSY);
  assign code       = code_sel;
  assign zero_err   = zero_err_q;

endmodule

// File: tb/tb_encoder_83_seq.sv
// Directed self-checking bench for encoder_83_seq; runs an MSB-first and an LSB-first instance side by side.
module tb_encoder_83_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req;
  logic       code_ready;

  logic       req_ready, code_valid, zero_err, multi_err;
  logic [2:0] code;
  logic       l_req_ready, l_code_valid, l_zero_err, l_multi_err;
  logic [2:0] l_code;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef ENCODER_83_SEQ_ONEHOT_CHECK_EN
  localparam logic MULTI_EXP = 1'b1;
`else
  localparam logic MULTI_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  encoder_83_seq #(.LSB_FIRST(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req(req),
    .req_ready(req_ready), .code(code), .code_valid(code_valid),
    .code_ready(code_ready), .zero_err(zero_err), .multi_err(multi_err)
  );

  encoder_83_seq #(.LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req(req),
    .req_ready(l_req_ready), .code(l_code), .code_valid(l_code_valid),
    .code_ready(code_ready), .zero_err(l_zero_err), .multi_err(l_multi_err)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req = 8'h00; code_ready = 1'b0;
    step(); step();
    tests_run++;
    if ({req_ready, code_valid, code, zero_err, multi_err} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rr=%b cv=%b code=%0d ze=%b me=%b expected rr=1 cv=0 code=0 ze=0 me=0",
               req_ready, code_valid, code, zero_err, multi_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 1'b1; req = 8'b0000_0100; code_ready = 1'b1;
    step();
    req_valid = 1'b0;
    tests_run++;
    if ({code_valid, req_ready, code} !== {1'b1, 1'b0, 3'd2}) begin
      tests_failed++;
      $display("FAIL single_code: got cv=%b rr=%b code=%0d expected cv=1 rr=0 code=2", code_valid, req_ready, code);
    end
    tests_run++;
    if (multi_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_no_multi: got %b expected 0", multi_err);
    end
    step();
    tests_run++;
    if ({code_valid, req_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_idle: got cv=%b rr=%b expected cv=0 rr=1", code_valid, req_ready);
    end
  endtask

  task automatic test_priority();
    logic [2:0] exp_msb [3];
    logic [2:0] exp_lsb [3];
    exp_msb = '{3'd7, 3'd5, 3'd0};
    exp_lsb = '{3'd0, 3'd5, 3'd7};
    req_valid = 1'b1; req = 8'b1010_0001; code_ready = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (!(code_valid === 1'b1 && code === exp_msb[k])) begin
        tests_failed++;
        $display("FAIL prio_msb[%0d]: got cv=%b code=%0d expected cv=1 code=%0d", k, code_valid, code, exp_msb[k]);
      end
      tests_run++;
      if (!(l_code_valid === 1'b1 && l_code === exp_lsb[k])) begin
        tests_failed++;
        $display("FAIL prio_lsb[%0d]: got cv=%b code=%0d expected cv=1 code=%0d", k, l_code_valid, l_code, exp_lsb[k]);
      end
      step();
    end
    tests_run++;
    if ({code_valid, req_ready, l_code_valid, l_req_ready} !== 4'b0101) begin
      tests_failed++;
      $display("FAIL prio_idle: got cv=%b rr=%b lcv=%b lrr=%b expected 0 1 0 1",
               code_valid, req_ready, l_code_valid, l_req_ready);
    end
  endtask

  task automatic test_back_to_back_stall();
    req_valid = 1'b1; req = 8'hFF; code_ready = 1'b1;
    step();
    for (int k = 7; k >= 0; k--) begin
      tests_run++;
      if (!(code_valid === 1'b1 && code === 3'(k))) begin
        tests_failed++;
        $display("FAIL stall_present[%0d]: got cv=%b code=%0d expected cv=1 code=%0d", k, code_valid, code, k);
      end
      // Stall cycle with a fresh request offered; it must be ignored.
      code_ready = 1'b0; req_valid = 1'b1; req = 8'h01;
      step();
      tests_run++;
      if (!(code_valid === 1'b1 && code === 3'(k) && req_ready === 1'b0)) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got cv=%b code=%0d rr=%b expected cv=1 code=%0d rr=0",
                 k, code_valid, code, req_ready, k);
      end
      code_ready = 1'b1; req_valid = 1'b0;
      step();
    end
    tests_run++;
    if ({code_valid, req_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL stall_idle: got cv=%b rr=%b expected cv=0 rr=1", code_valid, req_ready);
    end
  endtask

  task automatic test_zero();
    req_valid = 1'b1; req = 8'h00; code_ready = 1'b0;
    step();
    req_valid = 1'b0;
    tests_run++;
    if ({zero_err, code_valid, req_ready} !== 3'b101) begin
      tests_failed++;
      $display("FAIL zero_pulse: got ze=%b cv=%b rr=%b expected ze=1 cv=0 rr=1", zero_err, code_valid, req_ready);
    end
    step();
    tests_run++;
    if ({zero_err, code_valid, req_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL zero_after: got ze=%b cv=%b rr=%b expected ze=0 cv=0 rr=1", zero_err, code_valid, req_ready);
    end
    // A ready with nothing to present must not disturb anything.
    code_ready = 1'b1;
    step();
    tests_run++;
    if ({code_valid, req_ready, code} !== {1'b0, 1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL ready_noop: got cv=%b rr=%b code=%0d expected cv=0 rr=1 code=0", code_valid, req_ready, code);
    end
  endtask

  task automatic test_reset_mid_busy();
    req_valid = 1'b1; req = 8'hC3; code_ready = 1'b1;
    step();
    req_valid = 1'b0;
    tests_run++;
    if (code !== 3'd7) begin
      tests_failed++;
      $display("FAIL mid_first: got code=%0d expected 7", code);
    end
    step();
    tests_run++;
    if (code !== 3'd6) begin
      tests_failed++;
      $display("FAIL mid_second: got code=%0d expected 6", code);
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, code_valid, code, zero_err, multi_err} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_async_reset: got rr=%b cv=%b code=%0d ze=%b me=%b expected rr=1 cv=0 code=0 ze=0 me=0",
               req_ready, code_valid, code, zero_err, multi_err);
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if ({code_valid, req_ready} !== 2'b01) begin
        tests_failed++;
        $display("FAIL mid_no_codes[%0d]: got cv=%b rr=%b expected cv=0 rr=1", k, code_valid, req_ready);
      end
    end
  endtask

  task automatic test_multi();
    req_valid = 1'b1; req = 8'h18; code_ready = 1'b1;
    step();
    req_valid = 1'b0;
    tests_run++;
    if ({multi_err, code_valid, code} !== {MULTI_EXP, 1'b1, 3'd4}) begin
      tests_failed++;
      $display("FAIL multi_pulse: got me=%b cv=%b code=%0d expected me=%b cv=1 code=4",
               multi_err, code_valid, code, MULTI_EXP);
    end
    step();
    tests_run++;
    if ({multi_err, code_valid, code} !== {1'b0, 1'b1, 3'd3}) begin
      tests_failed++;
      $display("FAIL multi_after: got me=%b cv=%b code=%0d expected me=0 cv=1 code=3", multi_err, code_valid, code);
    end
    step();
    tests_run++;
    if ({code_valid, req_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL multi_idle: got cv=%b rr=%b expected cv=0 rr=1", code_valid, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_back_to_back_stall();
    test_zero();
    test_reset_mid_busy();
    test_multi();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
